// File: rtl/uart_rx_buf_con_if.sv
// Handshake bundle between the UART byte receiver, the frame buffer and the frame consumer.
interface uart_rx_buf_con_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] rbuf;
    logic [2:0]  bcount;
    logic        valid;
    logic        ack;
    logic        ovf;

    modport slave  (input rx_data, rx_valid, ack, output rbuf, bcount, valid, ovf);
    modport master (output rx_data, rx_valid, ack, input rbuf, bcount, valid, ovf);
endinterface

// File: rtl/uart_rx_buf_con.sv
// Assembles UART bytes into frames of up to 4 data bytes, closed by CR/LF and held until acked.
// Optional inter-byte idle timeout: define UART_RX_TIMEOUT_EN.
module uart_rx_buf_con #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_buf_con_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [2:0]  bcount_q, bcount_d;
    logic        ovf_q, ovf_d;
    logic        is_term, is_space, is_data;

    assign is_term  = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    assign is_space = (bus.rx_data == 8'h20);
    assign is_data  = !is_term && !is_space;

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d  = state_q;
        rbuf_d   = rbuf_q;
        bcount_d = bcount_q;
        ovf_d    = ovf_q;
`ifdef UART_RX_TIMEOUT_EN
        cnt_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.rx_valid && is_data) begin
                    rbuf_d   = {rbuf_q[23:0], bus.rx_data};
                    bcount_d = 3'd1;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.rx_valid) begin
                    if (is_data) begin
                        rbuf_d = {rbuf_q[23:0], bus.rx_data};
                        // Fifth and later bytes push out the oldest and flag the frame.
                        if (bcount_q == 3'd4) ovf_d = 1'b1;
                        else                  bcount_d = bcount_q + 3'd1;
                    end else if (is_term) begin
                        state_d = HOLD;
                    end
                end
`ifdef UART_RX_TIMEOUT_EN
                else if (cnt_inc == TMO) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            HOLD: begin
                if (bus.ack) begin
                    state_d  = IDLE;
                    rbuf_d   = '0;
                    bcount_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                rbuf_d   = '0;
                bcount_d = '0;
                ovf_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rbuf_q   <= '0;
            bcount_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rbuf_q   <= rbuf_d;
            bcount_q <= bcount_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.rbuf   = rbuf_q;
    assign bus.bcount = bcount_q;
    assign bus.ovf    = ovf_q;
    assign bus.valid  = (state_q == HOLD);
endmodule

// File: tb/tb_uart_rx_buf_con.sv
// Directed bench for uart_rx_buf_con; inputs change on negedge, outputs sampled on negedge.
module tb_uart_rx_buf_con;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    uart_rx_buf_con_if u_if ();

    uart_rx_buf_con #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        @(negedge clk);
        u_if.rx_valid = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        u_if.ack = 1'b1;
        @(negedge clk);
        u_if.ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_frame(input string tag, input logic [31:0] rb, input logic [2:0] bc,
                             input logic ov);
        chk({tag, "_valid"},  32'(u_if.valid), 32'd1);
        chk({tag, "_rbuf"},   u_if.rbuf, rb);
        chk({tag, "_bcount"}, 32'(u_if.bcount), 32'(bc));
        chk({tag, "_ovf"},    32'(u_if.ovf), 32'(ov));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"},  32'(u_if.valid), 32'd0);
        chk({tag, "_rbuf"},   u_if.rbuf, 32'd0);
        chk({tag, "_bcount"}, 32'(u_if.bcount), 32'd0);
        chk({tag, "_ovf"},    32'(u_if.ovf), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        u_if.rx_data  = 8'h00;
        u_if.rx_valid = 1'b0;
        u_if.ack      = 1'b0;
        idle(3);
        chk_empty("reset");
        rst_n = 1'b1;
        idle(1);

        // CR LF pair: one frame, the LF arrives with the ack and the ack wins
        send(8'h41);
        send(8'h42);
        chk("crlf_pre_valid", 32'(u_if.valid), 32'd0);
        send(8'h0D);
        chk_frame("crlf", 32'h0000_4142, 3'd2, 1'b0);
        @(negedge clk);
        u_if.rx_data = 8'h0A; u_if.rx_valid = 1'b1; u_if.ack = 1'b1;
        @(negedge clk);
        u_if.rx_valid = 1'b0; u_if.ack = 1'b0;
        chk_empty("crlf_acked");
        send(8'h0A);
        idle(2);
        chk_empty("crlf_lf_idle");

        // Spaces ignored, exactly 4 bytes
        send(8'h31); send(8'h32); send(8'h20); send(8'h33); send(8'h34); send(8'h0D);
        chk_frame("four", 32'h3132_3334, 3'd4, 1'b0);
        do_ack();
        chk_empty("four_acked");

        // Overflow keeps the newest four bytes
        for (int i = 1; i <= 6; i++) send(8'(i));
        chk("ovf_pre_valid", 32'(u_if.valid), 32'd0);
        send(8'h0D);
        chk_frame("ovf", 32'h0304_0506, 3'd4, 1'b1);
        do_ack();
        chk_empty("ovf_acked");

        // Bytes during HOLD are dropped; lone terminator after ack yields nothing
        send(8'h66); send(8'h0A);
        chk_frame("hold", 32'h0000_0066, 3'd1, 1'b0);
        send(8'h55);
        idle(2);
        chk_frame("hold_drop", 32'h0000_0066, 3'd1, 1'b0);
        do_ack();
        chk("hold_ack_valid", 32'(u_if.valid), 32'd0);
        send(8'h0D);
        idle(2);
        chk_empty("hold_lone_cr");

        // ack outside HOLD has no effect
        @(negedge clk);
        u_if.ack = 1'b1;
        send(8'h20);
        send(8'h48);
        chk("ack_idle_bcount", 32'(u_if.bcount), 32'd1);
        chk("ack_idle_valid", 32'(u_if.valid), 32'd0);
        u_if.ack = 1'b0;
        send(8'h0D);
        chk_frame("ack_idle", 32'h0000_0048, 3'd1, 1'b0);
        do_ack();

        // Reset mid-COLLECT discards the partial frame, clearing asynchronously
        send(8'h41);
        idle(2);
        #2 rst_n = 1'b0;
        #1 chk_empty("rst_collect");
        idle(2);
        rst_n = 1'b1;
        send(8'h42); send(8'h0D);
        chk_frame("rst_collect_after", 32'h0000_0042, 3'd1, 1'b0);

        // Reset mid-HOLD: no frame after release
        #2 rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(3);
        chk_empty("rst_hold");

        // Idle timeout
        send(8'h7A);
        idle(15);
        chk("tmo_early_valid", 32'(u_if.valid), 32'd0);
        idle(1);
`ifdef UART_RX_TIMEOUT_EN
        chk_frame("tmo", 32'h0000_007A, 3'd1, 1'b0);
        do_ack();
        chk_empty("tmo_acked");
`else
        idle(20);
        chk("notmo_valid", 32'(u_if.valid), 32'd0);
        chk("notmo_bcount", 32'(u_if.bcount), 32'd1);
        chk("notmo_rbuf", u_if.rbuf, 32'h0000_007A);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_buf_con.md
UART_RX_BUF_CON -- requirements
Module: uart_rx_buf_con

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, inter-byte idle limit in clk cycles (used only with UART_RX_TIMEOUT_EN).
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8  received byte from UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data valid this cycle.
REQ-006 rbuf  output  32  assembled frame, last byte received in [7:0].
REQ-007 bcount  output  3  number of data bytes in rbuf, 0..4.
REQ-008 valid  output  1  frame available; held until accepted.
REQ-009 ack  input  1  consumer accept; frame consumed when valid && ack.
REQ-010 ovf  output  1  current/presented frame had more than 4 data bytes.

Function
REQ-011 States SHALL be IDLE, COLLECT, HOLD.
REQ-012 IDLE: rx_valid with data byte -> shift in, bcount=1, go COLLECT; rx_valid with 0x0D, 0x0A or 0x20 -> ignored, stay IDLE.
REQ-013 Data byte = any byte other than 0x0D, 0x0A, 0x20.
REQ-014 COLLECT data byte: rbuf <= {rbuf[23:0], rx_data}; bcount <= bcount+1 saturating at 4.
REQ-015 COLLECT data byte with bcount==4: byte still shifted in (oldest byte discarded), bcount stays 4, ovf <= 1.
REQ-016 COLLECT 0x20: ignored, no state change.
REQ-017 COLLECT 0x0D or 0x0A: go HOLD, valid=1 on the next cycle after the strobe (latency 1).
REQ-018 HOLD: rbuf, bcount, ovf SHALL remain stable while valid=1.
REQ-019 HOLD with valid && ack: next cycle valid=0, rbuf=0, bcount=0, ovf=0, state IDLE.
REQ-020 HOLD with rx_valid (any byte) and no ack same cycle: byte dropped, no state change.
REQ-021 HOLD with rx_valid and ack same cycle: ack wins, byte dropped, state IDLE.
REQ-022 CR LF pair SHALL produce exactly one frame; second terminator lands in IDLE and is ignored.
REQ-023 ack outside HOLD SHALL be ignored.
REQ-024 valid SHALL never be asserted with bcount==0.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, rbuf=0, bcount=0, valid=0, ovf=0, timeout counter=0.
REQ-026 Reset mid-COLLECT or mid-HOLD SHALL discard the partial/pending frame with no valid pulse after release.
REQ-027 First rx_valid honoured is the first rising edge with rst_n high.

Configuration
REQ-028 Macro UART_RX_TIMEOUT_EN defined: counter resets on each rx_valid in COLLECT, increments each idle COLLECT cycle; on reaching TIMEOUT_CYCLES, go HOLD and present partial frame exactly as on terminator.
REQ-029 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); counter held at 0 outside COLLECT.
REQ-030 Macro undefined: no counter logic synthesised; COLLECT exits only on terminator or reset.

Verification
REQ-031 Bytes 0x41,0x42,0x0D,0x0A -> valid 1 cycle after 0x0D, rbuf=0x00004142, bcount=2, ovf=0; only one frame.
REQ-032 Bytes 0x31,0x32,0x20,0x33,0x34,0x0D -> rbuf=0x31323334, bcount=4, ovf=0.
REQ-033 Bytes 0x01..0x06,0x0D -> rbuf=0x03040506, bcount=4, ovf=1.
REQ-034 Frame held with ack=0, send 0x55 -> rbuf unchanged; then ack=1 -> valid=0 next cycle, later 0x0D alone produces no frame.
REQ-035 rst_n low 2 cycles after 0x41 then bytes 0x42,0x0D -> rbuf=0x00000042, bcount=1.
REQ-036 UART_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: byte 0x7A then silence -> valid after 16 idle cycles, rbuf=0x0000007A, bcount=1; without macro valid stays 0.
